fetch_mem_unit_param: RTL and testbench

- Parametrised next-generation fetch/memory stage for the multi-cycle processor.
- Holds PC, IR and MDR plus a unified instruction/data memory. Memory access is multi-cycle: a request/busy/done handshake with a configurable wait-state count.
- Resolves branches on ALU flags.
- Sits between the control FSM (request, write enables, IorD) and the register file/ALU (IR, MDR and ALUOut paths).

---
 rtl/fetch_mem_unit_param.sv | 105 ++++++++++
 tb/tb_fetch_mem_unit_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit_param.sv
// fetch_mem_unit_param: PC/IR/MDR fetch-memory stage with multi-cycle unified memory and branch resolution
module fetch_mem_unit_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_BITS = 10,
  parameter int MEM_LATENCY = 2,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              input_PC_PCWrite,
  input  logic [DATA_W-1:0] input_PC_newPC,
  input  logic              input_PC_isBranch,
  input  logic [1:0]        input_branchType,
  input  logic              input_zero,
  input  logic              input_negative,
  input  logic              input_mem_req,
  input  logic              IorD,
  input  logic [DATA_W-1:0] input_from_ALUOut,
  input  logic              input_mem_write,
  input  logic [DATA_W-1:0] input_mem_data,
  input  logic              input_IR_write,
  output logic              output_mem_busy,
  output logic              output_mem_done,
  output logic [DATA_W-1:0] output_PC,
  output logic [DATA_W-1:0] output_IR,
  output logic [DATA_W-1:0] output_MDR
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  logic [DATA_W-1:0]    r_mem [2**ADDR_BITS];
  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_we;
  logic                 r_iord;
  logic                 r_irw;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_pc;
  logic [DATA_W-1:0]    r_ir;
  logic [DATA_W-1:0]    r_mdr;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_cond;
  logic                 w_pc_load;
  logic [ADDR_BITS-1:0] w_addr;
  logic [1:0]           w_next;
  logic                 w_unused;
  assign w_unused = ^input_from_ALUOut;
  always_comb begin
    w_cond = input_branchType[1] ? (input_negative ^ input_branchType[0])
                                 : (input_zero ^ input_branchType[0]);
    w_pc_load = input_PC_PCWrite | (input_PC_isBranch & w_cond);
    w_addr = IorD ? input_from_ALUOut[ADDR_BITS-1:0] : r_pc[ADDR_BITS-1:0];
    w_next = (r_state == S_IDLE) ? (input_mem_req ? ((MEM_LATENCY == 0) ? S_ACCESS : S_WAIT) : S_IDLE)
           : (r_state == S_WAIT) ? ((r_cnt == 4'd0) ? S_ACCESS : S_WAIT)
           : S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!Reset && r_state == S_ACCESS && r_we)
      r_mem[r_addr] <= r_wdata;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc <= PC_RESET;
      r_ir <= '0;
      r_mdr <= '0;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_addr <= '0;
      r_we <= 1'b0;
      r_iord <= 1'b0;
      r_irw <= 1'b0;
      r_wdata <= '0;
    end else begin
      if (w_pc_load)
        r_pc <= input_PC_newPC;
      r_state <= w_next;
      r_busy <= w_next != S_IDLE;
      r_done <= r_state == S_ACCESS;
      if (r_state == S_IDLE && input_mem_req) begin
        r_addr <= w_addr;
        r_we <= input_mem_write;
        r_wdata <= input_mem_data;
        r_iord <= IorD;
        r_irw <= input_IR_write;
        r_cnt <= 4'(MEM_LATENCY - 1);
      end
      if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_ACCESS && !r_we && r_iord)
        r_mdr <= r_mem[r_addr];
      if (r_state == S_ACCESS && !r_we && !r_iord && r_irw)
        r_ir <= r_mem[r_addr];
    end
  end
  assign output_mem_busy = r_busy;
  assign output_mem_done = r_done;
  assign output_PC = r_pc;
  assign output_IR = r_ir;
  assign output_MDR = r_mdr;
endmodule

// File: tb/tb_fetch_mem_unit_param.sv
// tb_fetch_mem_unit_param: directed plus randomized checks of the fetch/memory stage
// against a word-level model (memory array, PC/IR/MDR variables, latency count).
module tb_fetch_mem_unit_param;
  logic        CLK = 0;
  logic        Reset = 1;
  logic        pcw = 0;
  logic [15:0] new_pc = 0;
  logic        is_br = 0;
  logic [1:0]  br_type = 0;
  logic        zero = 0;
  logic        neg = 0;
  logic        req = 0;
  logic        req0 = 0;
  logic        iord = 0;
  logic [15:0] alu = 0;
  logic        mw = 0;
  logic [15:0] md = 0;
  logic        irw = 0;
  logic        busy, done, busy0, done0;
  logic [15:0] pc, ir, mdr, pc0, ir0, mdr0;
  int          vec = 0;
  int          errs = 0;
  logic [15:0] mm [1024];
  logic [15:0] pc_m, ir_m, mdr_m;
  int          wq[$];

  always #5 CLK = ~CLK;

  fetch_mem_unit_param #(.MEM_LATENCY(2)) dut (
    .CLK(CLK), .Reset(Reset), .input_PC_PCWrite(pcw), .input_PC_newPC(new_pc),
    .input_PC_isBranch(is_br), .input_branchType(br_type), .input_zero(zero),
    .input_negative(neg), .input_mem_req(req), .IorD(iord), .input_from_ALUOut(alu),
    .input_mem_write(mw), .input_mem_data(md), .input_IR_write(irw),
    .output_mem_busy(busy), .output_mem_done(done), .output_PC(pc),
    .output_IR(ir), .output_MDR(mdr));

  fetch_mem_unit_param #(.MEM_LATENCY(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .input_PC_PCWrite(pcw), .input_PC_newPC(new_pc),
    .input_PC_isBranch(is_br), .input_branchType(br_type), .input_zero(zero),
    .input_negative(neg), .input_mem_req(req0), .IorD(iord), .input_from_ALUOut(alu),
    .input_mem_write(mw), .input_mem_data(md), .input_IR_write(irw),
    .output_mem_busy(busy0), .output_mem_done(done0), .output_PC(pc0),
    .output_IR(ir0), .output_MDR(mdr0));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    pcw = 1;
    new_pc = v;
    tick();
    pcw = 0;
    pc_m = v;
    chk("set_pc", pc, pc_m);
  endtask

  // One access on the latency-2 unit; PC is reloaded mid-flight to show the address was captured.
  task automatic access(input logic a_iord, input logic a_we, input logic a_irw,
                        input logic [15:0] a_alu, input logic [15:0] a_data, input bit hold);
    logic [9:0]  a;
    logic [15:0] np;
    int          lat;
    a = a_iord ? a_alu[9:0] : pc_m[9:0];
    req = 1; iord = a_iord; mw = a_we; irw = a_irw; alu = a_alu; md = a_data;
    tick();
    chk("busy_start", busy, 1);
    req = hold;
    iord = $urandom; mw = $urandom; irw = $urandom; alu = $urandom; md = $urandom;
    np = $urandom;
    pcw = 1;
    new_pc = np;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      if (lat == 0) begin
        pc_m = np;
        pcw = 0;
      end
      lat++;
    end
    req = 0;
    chk("latency", lat, 3);
    if (a_we) mm[a] = a_data;
    else if (a_iord) mdr_m = mm[a];
    else if (a_irw) ir_m = mm[a];
    chk("ir", ir, ir_m);
    chk("mdr", mdr, mdr_m);
    chk("pc_during_access", pc, pc_m);
    chk("busy_at_done", busy, 0);
    if (hold) begin
      tick();
      tick();
      chk("no_queued_done", done, 0);
      chk("no_queued_busy", busy, 0);
    end
  endtask

  function automatic bit taken(input logic [1:0] t, input logic z, input logic n);
    case (t)
      2'b00: return z;
      2'b01: return !z;
      2'b10: return n;
      default: return !n;
    endcase
  endfunction

  initial begin
    logic [15:0] d;
    int          r;
    int          a;
    tick();
    Reset = 0;
    pc_m = 0; ir_m = 0; mdr_m = 0;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    access(1, 1, 0, 16'h0002, 16'h1234, 0);
    access(1, 1, 0, 16'h0001, 16'hBEEF, 0);
    access(1, 1, 0, 16'h0020, 16'h1111, 0);
    set_pc(16'h0002);
    access(0, 0, 1, 16'h0000, 16'h0000, 0);
    chk("fetch_ir", ir, 16'h1234);
    access(1, 0, 0, 16'h0001, 16'h0000, 0);
    chk("load_mdr", mdr, 16'hBEEF);
    chk("load_ir_kept", ir, 16'h1234);
    access(1, 0, 0, 16'h0401, 16'h0000, 0);
    chk("wrap_mdr", mdr, 16'hBEEF);
    access(1, 1, 0, 16'h0010, 16'hCAFE, 1);
    chk("write_keeps_mdr", mdr, 16'hBEEF);
    access(1, 0, 0, 16'h0010, 16'h0000, 1);
    chk("readback", mdr, 16'hCAFE);
    for (int t = 0; t < 4; t++) begin
      for (int f = 0; f < 2; f++) begin
        set_pc(16'h0007);
        br_type = 2'(t);
        zero = (t < 2) ? 1'(f) : 1'($urandom);
        neg = (t >= 2) ? 1'(f) : 1'($urandom);
        is_br = 1;
        new_pc = 16'h0040;
        tick();
        is_br = 0;
        if (taken(br_type, zero, neg)) pc_m = 16'h0040;
        chk($sformatf("branch_t%0d_f%0d", t, f), pc, pc_m);
      end
    end
    set_pc(16'h0007);
    br_type = 2'b00; zero = 0; is_br = 1; pcw = 1; new_pc = 16'h0040;
    tick();
    is_br = 0; pcw = 0;
    chk("pcwrite_override", pc, 16'h0040);
    pc_m = 16'h0040;
    req = 1; iord = 1; mw = 1; alu = 16'h0020; md = 16'h5555;
    tick();
    req = 0; mw = 0;
    tick();
    Reset = 1;
    tick();
    Reset = 0;
    pc_m = 0; ir_m = 0; mdr_m = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_mdr", mdr, 0);
    tick();
    tick();
    chk("midrst_no_done", done, 0);
    access(1, 0, 0, 16'h0020, 16'h0000, 0);
    chk("midrst_old_value", mdr, 16'h1111);
    wq.push_back(1); wq.push_back(2); wq.push_back(16); wq.push_back(32);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        d = $urandom;
        a = $urandom_range(0, 1023);
        access(1, 1, 0, {6'($urandom), 10'(a)}, d, bit'($urandom));
        wq.push_back(a);
      end else if (r == 1) begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        access(1, 0, 0, {6'($urandom), 10'(a)}, 16'($urandom), bit'($urandom));
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        set_pc({6'($urandom), 10'(a)});
        access(0, 0, 1'($urandom), 16'($urandom), 16'($urandom), bit'($urandom));
      end
    end
    iord = 1; mw = 1; alu = 16'h0005; md = 16'hA5A5; req0 = 1;
    tick();
    chk("l0_busy", busy0, 1);
    chk("l0_no_done", done0, 0);
    mw = 0;
    tick();
    chk("l0_done", done0, 1);
    chk("l0_write_mdr", mdr0, 0);
    tick();
    chk("l0_b2b_busy", busy0, 1);
    chk("l0_b2b_no_done", done0, 0);
    tick();
    req0 = 0;
    chk("l0_b2b_done", done0, 1);
    chk("l0_readback", mdr0, 16'hA5A5);
    tick();
    chk("l0_idle_done", done0, 0);
    chk("l0_idle_busy", busy0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
